// File: rtl/hsid_mse_comp.sv
// hsid_mse_comp
//   Scans a stream of MSE results from a hyperspectral library search and
//   tracks the smallest and largest MSE together with the library reference
//   that produced each one.
//
// Parameters
//   WORD_WIDTH        width of MSE values
//   HSP_LIBRARY_WIDTH width of library references, size and result count
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   clear             synchronous soft clear, same effect as rst
//   start             begin a scan; only honoured while idle
//   hsp_library_size  number of results in the scan, sampled with start
//   mse_value/mse_ref/mse_valid/acc_of  upstream MSE result stream
//   mse_min_value/mse_min_ref          smallest MSE seen and its reference
//   mse_max_value/mse_max_ref          largest MSE seen and its reference
//   idle              high in IDLE
//   done              one-cycle pulse after the last result is counted
//   of_seen           sticky: some result in this scan had acc_of set
//   state_dbg         current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: the stream has no backpressure. A result is transferred on
// every rising edge where mse_valid=1 while the FSM is in RUN; mse_valid
// is ignored in any other state.
//
// Build option
//   HSID_MSE_COMP_OF_FILTER_EN  when defined, overflowed results (acc_of=1)
//   are counted and flag of_seen but never enter the min/max comparison.

package hsid_pkg;
  localparam int HSID_WORD_WIDTH        = 16;
  localparam int HSID_HSP_LIBRARY_WIDTH = 8;
endpackage

module hsid_mse_comp #(
  parameter int WORD_WIDTH        = hsid_pkg::HSID_WORD_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = hsid_pkg::HSID_HSP_LIBRARY_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         start,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
  input  logic [WORD_WIDTH-1:0]        mse_value,
  input  logic [HSP_LIBRARY_WIDTH-1:0] mse_ref,
  input  logic                         mse_valid,
  input  logic                         acc_of,
  output logic [WORD_WIDTH-1:0]        mse_min_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
  output logic [WORD_WIDTH-1:0]        mse_max_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
  output logic                         idle,
  output logic                         done,
  output logic                         of_seen,
  output logic [1:0]                   state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [HSP_LIBRARY_WIDTH-1:0]   count_q, count_d;
  logic [HSP_LIBRARY_WIDTH-1:0]   size_q, size_d;
  logic [WORD_WIDTH-1:0]          min_val_q, min_val_d;
  logic [HSP_LIBRARY_WIDTH-1:0]   min_ref_q, min_ref_d;
  logic [WORD_WIDTH-1:0]          max_val_q, max_val_d;
  logic [HSP_LIBRARY_WIDTH-1:0]   max_ref_q, max_ref_d;
  // have_q marks that the min/max pairs hold a real result. With filtering
  // enabled the first counted result may be skipped, so count_q alone
  // cannot tell whether the pairs are loaded.
  logic                           have_q, have_d;
  logic                           of_q, of_d;
  logic                           use_res;
  logic [HSP_LIBRARY_WIDTH-1:0]   count_inc;

`ifdef HSID_MSE_COMP_OF_FILTER_EN
  assign use_res = ~acc_of;
`else
  assign use_res = 1'b1;
`endif

  // count_q < size_q in RUN, so this never wraps.
  assign count_inc = count_q + {{(HSP_LIBRARY_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    size_d    = size_q;
    min_val_d = min_val_q;
    min_ref_d = min_ref_q;
    max_val_d = max_val_q;
    max_ref_d = max_ref_q;
    have_d    = have_q;
    of_d      = of_q;
    if (clear) begin
      state_d   = S_IDLE;
      count_d   = '0;
      size_d    = '0;
      min_val_d = '0;
      min_ref_d = '0;
      max_val_d = '0;
      max_ref_d = '0;
      have_d    = 1'b0;
      of_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_d   = '0;
            size_d    = hsp_library_size;
            min_val_d = '0;
            min_ref_d = '0;
            max_val_d = '0;
            max_ref_d = '0;
            have_d    = 1'b0;
            of_d      = 1'b0;
            state_d   = (hsp_library_size == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (mse_valid) begin
            count_d = count_inc;
            if (acc_of) of_d = 1'b1;
            if (use_res) begin
              if (!have_q) begin
                min_val_d = mse_value;
                min_ref_d = mse_ref;
                max_val_d = mse_value;
                max_ref_d = mse_ref;
                have_d    = 1'b1;
              end else begin
                // Strict compares keep the earliest reference on ties.
                if (mse_value < min_val_q) begin
                  min_val_d = mse_value;
                  min_ref_d = mse_ref;
                end
                if (mse_value > max_val_q) begin
                  max_val_d = mse_value;
                  max_ref_d = mse_ref;
                end
              end
            end
            if (count_inc == size_q) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      size_q    <= '0;
      min_val_q <= '0;
      min_ref_q <= '0;
      max_val_q <= '0;
      max_ref_q <= '0;
      have_q    <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      size_q    <= size_d;
      min_val_q <= min_val_d;
      min_ref_q <= min_ref_d;
      max_val_q <= max_val_d;
      max_ref_q <= max_ref_d;
      have_q    <= have_d;
      of_q      <= of_d;
    end
  end

  assign mse_min_value = min_val_q;
  assign mse_min_ref   = min_ref_q;
  assign mse_max_value = max_val_q;
  assign mse_max_ref   = max_ref_q;
  assign idle          = (state_q == S_IDLE);
  assign done          = (state_q == S_DONE);
  assign of_seen       = of_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_hsid_mse_comp.sv
// tb_hsid_mse_comp
//   Directed bench for hsid_mse_comp. Each scan pushes its expected final
//   {of_seen, min value, min ref, max value, max ref} onto exp_q; a monitor
//   pops and compares whenever the DUT pulses done.

module tb_hsid_mse_comp;
  localparam int W  = 16;
  localparam int L  = 8;
  localparam int EW = 1 + W + L + W + L;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [L-1:0] hsp_library_size = '0;
  logic [W-1:0] mse_value = '0;
  logic [L-1:0] mse_ref = '0;
  logic         mse_valid = 1'b0;
  logic         acc_of = 1'b0;
  logic [W-1:0] mse_min_value, mse_max_value;
  logic [L-1:0] mse_min_ref, mse_max_ref;
  logic         idle, done, of_seen;
  logic [1:0]   state_dbg;

  hsid_mse_comp #(.WORD_WIDTH(W), .HSP_LIBRARY_WIDTH(L)) dut (
    .clk(clk), .rst(rst), .clear(clear), .start(start),
    .hsp_library_size(hsp_library_size),
    .mse_value(mse_value), .mse_ref(mse_ref), .mse_valid(mse_valid),
    .acc_of(acc_of),
    .mse_min_value(mse_min_value), .mse_min_ref(mse_min_ref),
    .mse_max_value(mse_max_value), .mse_max_ref(mse_max_ref),
    .idle(idle), .done(done), .of_seen(of_seen), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic prev_done = 1'b0;

  function automatic logic [EW-1:0] mk(input logic o, input logic [W-1:0] mn,
                                       input logic [L-1:0] mr, input logic [W-1:0] mx,
                                       input logic [L-1:0] xr);
    return {o, mn, mr, mx, xr};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] got, e;
    if (done === 1'b1) begin
      checks++;
      got = mk(of_seen, mse_min_value, mse_min_ref, mse_max_value, mse_max_ref);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got of=%0d min=%0d/%0d max=%0d/%0d with no scan pending",
                 got[EW-1], got[EW-2 -: W], got[2*L+W-1 -: L], got[L+W-1 -: W], got[L-1:0]);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL scan_result got of=%0d min=%0d/%0d max=%0d/%0d exp of=%0d min=%0d/%0d max=%0d/%0d",
                   got[EW-1], got[EW-2 -: W], got[2*L+W-1 -: L], got[L+W-1 -: W], got[L-1:0],
                   e[EW-1], e[EW-2 -: W], e[2*L+W-1 -: L], e[L+W-1 -: W], e[L-1:0]);
        end
      end
    end
    if (prev_done) begin
      checks++;
      if (done !== 1'b0 || idle !== 1'b1) begin
        errors++;
        $display("FAIL done_width got done=%0b idle=%0b exp done=0 idle=1", done, idle);
      end
    end
    prev_done = (done === 1'b1);
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [L-1:0] sz);
    start = 1'b1;
    hsp_library_size = sz;
    cyc();
    start = 1'b0;
  endtask

  task automatic res(input logic [L-1:0] r, input logic [W-1:0] v, input logic o);
    mse_valid = 1'b1;
    mse_ref = r;
    mse_value = v;
    acc_of = o;
    cyc();
    mse_valid = 1'b0;
    acc_of = 1'b0;
  endtask

  task automatic wait_sb();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      cyc();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got pending=%0d exp 0", exp_q.size());
      exp_q.delete();
    end
    cyc();
    chk("idle_after_done", {31'd0, idle}, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_min"}, {16'd0, mse_min_value}, 32'd0);
    chk({tag, "_minref"}, {24'd0, mse_min_ref}, 32'd0);
    chk({tag, "_max"}, {16'd0, mse_max_value}, 32'd0);
    chk({tag, "_maxref"}, {24'd0, mse_max_ref}, 32'd0);
    chk({tag, "_of"}, {31'd0, of_seen}, 32'd0);
    chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    chk_zero("reset");
    chk("reset_done", {31'd0, done}, 32'd0);
    cyc();

    // basic scan, with latency-1 check on the first result
    exp_q.push_back(mk(1'b0, 16'd5, 8'd2, 16'd21, 8'd1));
    do_start(8'd3);
    chk("start_idle_low", {31'd0, idle}, 32'd0);
    res(8'd0, 16'd9, 1'b0);
    chk("first_min", {16'd0, mse_min_value}, 32'd9);
    chk("first_max", {16'd0, mse_max_value}, 32'd9);
    res(8'd1, 16'd21, 1'b0);
    res(8'd2, 16'd5, 1'b0);
    wait_sb();

    // overflow
`ifdef HSID_MSE_COMP_OF_FILTER_EN
    exp_q.push_back(mk(1'b1, 16'd8, 8'd1, 16'd8, 8'd1));
`else
    exp_q.push_back(mk(1'b1, 16'd3, 8'd0, 16'd8, 8'd1));
`endif
    do_start(8'd2);
    res(8'd0, 16'd3, 1'b1);
    res(8'd1, 16'd8, 1'b0);
    wait_sb();
    repeat (2) cyc();
    chk("of_sticky_idle", {31'd0, of_seen}, 32'd1);

    // ties: earliest reference wins, and the new start clears of_seen
    exp_q.push_back(mk(1'b0, 16'd7, 8'd0, 16'd7, 8'd0));
    do_start(8'd2);
    res(8'd0, 16'd7, 1'b0);
    res(8'd1, 16'd7, 1'b0);
    wait_sb();

    // gaps with a start pulse during RUN
    exp_q.push_back(mk(1'b0, 16'd2, 8'd1, 16'd10, 8'd0));
    do_start(8'd2);
    res(8'd0, 16'd10, 1'b0);
    cyc();
    do_start(8'd5);
    cyc();
    cyc();
    chk("gap_no_done", {31'd0, done}, 32'd0);
    res(8'd1, 16'd2, 1'b0);
    wait_sb();

    // zero size: results cleared even though the previous scan left data
    exp_q.push_back(mk(1'b0, 16'd0, 8'd0, 16'd0, 8'd0));
    do_start(8'd0);
    wait_sb();

    // mid-scan reset
    do_start(8'd3);
    res(8'd0, 16'd6, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_zero("midrst");
    repeat (4) cyc();
    exp_q.push_back(mk(1'b0, 16'd4, 8'd0, 16'd4, 8'd0));
    do_start(8'd1);
    res(8'd0, 16'd4, 1'b0);
    wait_sb();

    // mid-scan clear, colliding with a result and a start
    do_start(8'd3);
    res(8'd0, 16'd6, 1'b1);
    clear = 1'b1;
    start = 1'b1;
    hsp_library_size = 8'd1;
    mse_valid = 1'b1;
    mse_ref = 8'd1;
    mse_value = 16'd1;
    cyc();
    clear = 1'b0;
    start = 1'b0;
    mse_valid = 1'b0;
    chk_zero("midclr");
    repeat (4) cyc();
    exp_q.push_back(mk(1'b0, 16'd4, 8'd0, 16'd4, 8'd0));
    do_start(8'd1);
    res(8'd0, 16'd4, 1'b0);
    wait_sb();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
